// File: rtl/dispatch_ctrl_pkg.sv
// Shared constants for the dispatch credit controller.
// Default structure sizes, credit width helpers and FSM state encoding.
package dispatch_ctrl_pkg;

    localparam int unsigned DCTRL_RS_SIZE  = 16;
    localparam int unsigned DCTRL_LSB_SIZE = 16;
    localparam int unsigned DCTRL_ROB_SIZE = 16;

    // Counter width able to hold every value 0..size inclusive
    function automatic int unsigned dctrl_credit_w(input int unsigned size);
        return $clog2(size + 1);
    endfunction

    typedef enum logic {
        DCTRL_RUN   = 1'b0,
        DCTRL_FLUSH = 1'b1
    } dctrl_state_e;

endpackage

// File: rtl/dispatch_credit_ctr.sv
// Saturating free-slot counter for one back-end structure.
// take consumes a slot, give returns one, restore refills to SIZE.
module dispatch_credit_ctr
    import dispatch_ctrl_pkg::*;
#(
    parameter int unsigned SIZE = 16
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             en_i,
    input  logic                             take_i,
    input  logic                             give_i,
    input  logic                             restore_i,
    output logic [$clog2(SIZE+1)-1:0]        count_o
);

    localparam int unsigned W = $clog2(SIZE + 1);
    localparam logic [W-1:0] FULL = W'(SIZE);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next credit: restore wins, take+give cancel, give saturates at FULL
    always_comb begin
        count_d = count_q;
        if (restore_i) begin
            count_d = FULL;
        end else if (take_i && !give_i) begin
            count_d = count_q - W'(1);
        end else if (give_i && !take_i && (count_q != FULL)) begin
            count_d = count_q + W'(1);
        end
    end

    // Credit register, frozen while the global enable is low
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= FULL;
        end else if (en_i) begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/dispatch_ctrl.sv
// Credit-based issue controller beside the dispatch stage.
// Tracks free RS/LSB/ROB slots, emits registered dispatch pulses and a
// combinational fetch stall; a flush refills all credits.
// Optional: DISPATCH_CTRL_PERF_EN adds the stall_cycles counter output.
module dispatch_ctrl
    import dispatch_ctrl_pkg::*;
#(
    parameter int unsigned RS_SIZE  = DCTRL_RS_SIZE,
    parameter int unsigned LSB_SIZE = DCTRL_LSB_SIZE,
    parameter int unsigned ROB_SIZE = DCTRL_ROB_SIZE
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic                              rdy_in,
    input  logic                              dec_valid,
    input  logic                              dec_is_mem,
    input  logic                              rs_release,
    input  logic                              lsb_release,
    input  logic                              rob_commit,
    input  logic                              flush,
    output logic                              fetch_stall,
    output logic                              issue_rs,
    output logic                              issue_lsb,
    output logic                              issue_rob,
    output logic [$clog2(RS_SIZE+1)-1:0]      rs_credit,
    output logic [$clog2(LSB_SIZE+1)-1:0]     lsb_credit,
    output logic [$clog2(ROB_SIZE+1)-1:0]     rob_credit
`ifdef DISPATCH_CTRL_PERF_EN
    ,
    output logic [31:0]                       stall_cycles
`endif
);

    dctrl_state_e state_q;
    logic         issue_rs_q;
    logic         issue_lsb_q;
    logic         issue_rob_q;

    logic can_issue;
    logic fire;
    logic in_run;

    assign in_run    = (state_q == DCTRL_RUN);
    assign can_issue = dec_valid & (rob_credit != '0) &
                       (dec_is_mem ? (lsb_credit != '0) : (rs_credit != '0));
    assign fire      = rdy_in & in_run & ~flush & can_issue;

    assign fetch_stall = rst_in | ~in_run | flush | (dec_valid & ~can_issue);

    // Releases arriving in the FLUSH cycle are dropped; credits are already full
    dispatch_credit_ctr #(.SIZE(RS_SIZE)) u_rs_ctr (
        .clk_i     (clk_in),
        .rst_i     (rst_in),
        .en_i      (rdy_in),
        .take_i    (fire & ~dec_is_mem),
        .give_i    (rs_release & in_run),
        .restore_i (flush),
        .count_o   (rs_credit)
    );

    dispatch_credit_ctr #(.SIZE(LSB_SIZE)) u_lsb_ctr (
        .clk_i     (clk_in),
        .rst_i     (rst_in),
        .en_i      (rdy_in),
        .take_i    (fire & dec_is_mem),
        .give_i    (lsb_release & in_run),
        .restore_i (flush),
        .count_o   (lsb_credit)
    );

    dispatch_credit_ctr #(.SIZE(ROB_SIZE)) u_rob_ctr (
        .clk_i     (clk_in),
        .rst_i     (rst_in),
        .en_i      (rdy_in),
        .take_i    (fire),
        .give_i    (rob_commit & in_run),
        .restore_i (flush),
        .count_o   (rob_credit)
    );

    // Control FSM with registered one-cycle issue pulses
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= DCTRL_RUN;
            issue_rs_q  <= 1'b0;
            issue_lsb_q <= 1'b0;
            issue_rob_q <= 1'b0;
        end else if (!rdy_in) begin
            issue_rs_q  <= 1'b0;
            issue_lsb_q <= 1'b0;
            issue_rob_q <= 1'b0;
        end else begin
            issue_rob_q <= fire;
            issue_rs_q  <= fire & ~dec_is_mem;
            issue_lsb_q <= fire & dec_is_mem;
            state_q     <= flush ? DCTRL_FLUSH : DCTRL_RUN;
        end
    end

    assign issue_rs  = issue_rs_q;
    assign issue_lsb = issue_lsb_q;
    assign issue_rob = issue_rob_q;

`ifdef DISPATCH_CTRL_PERF_EN
    logic [31:0] stall_cycles_q;

    // Saturating count of enabled cycles where a valid instruction is held back
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            stall_cycles_q <= '0;
        end else if (rdy_in && fetch_stall && dec_valid && in_run &&
                     (stall_cycles_q != '1)) begin
            stall_cycles_q <= stall_cycles_q + 32'd1;
        end
    end

    assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Self-checking bench for dispatch_ctrl: directed scenarios then random
// traffic, all checked against a slot-count reference model.
module tb_dispatch_ctrl;

    localparam int RS  = 16;
    localparam int LSB = 16;
    localparam int ROB = 16;

    logic clk_in = 1'b0;
    logic rst_in, rdy_in, dec_valid, dec_is_mem;
    logic rs_release, lsb_release, rob_commit, flush;
    logic fetch_stall, issue_rs, issue_lsb, issue_rob;
    logic [4:0] rs_credit, lsb_credit, rob_credit;
`ifdef DISPATCH_CTRL_PERF_EN
    logic [31:0] stall_cycles;
`endif

    always #5 clk_in = ~clk_in;

    dispatch_ctrl #(.RS_SIZE(RS), .LSB_SIZE(LSB), .ROB_SIZE(ROB)) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rdy_in      (rdy_in),
        .dec_valid   (dec_valid),
        .dec_is_mem  (dec_is_mem),
        .rs_release  (rs_release),
        .lsb_release (lsb_release),
        .rob_commit  (rob_commit),
        .flush       (flush),
        .fetch_stall (fetch_stall),
        .issue_rs    (issue_rs),
        .issue_lsb   (issue_lsb),
        .issue_rob   (issue_rob),
        .rs_credit   (rs_credit),
        .lsb_credit  (lsb_credit),
        .rob_credit  (rob_credit)
`ifdef DISPATCH_CTRL_PERF_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

    int tests = 0;
    int fails = 0;

    // Reference model: free slot counts and a "just flushed" flag
    int    m_rs, m_lsb, m_rob;
    bit    m_flushing;
    bit    e_rs, e_lsb, e_rob;
    longint m_stall;
    bit    last_stall;
    bit    last_dv, last_mem;

    function automatic int cap(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit r, input bit rdy, input bit dv, input bit mem,
                        input bit rr, input bit lr, input bit rc, input bit fl);
        bit can, stall, iss;
        rst_in = r; rdy_in = rdy; dec_valid = dv; dec_is_mem = mem;
        rs_release = rr; lsb_release = lr; rob_commit = rc; flush = fl;
        #2;
        can   = dv && (m_rob > 0) && (mem ? (m_lsb > 0) : (m_rs > 0));
        stall = r || m_flushing || fl || (dv && !can);
        chk("fetch_stall", {31'b0, fetch_stall}, {31'b0, stall});
        @(posedge clk_in);
        if (r) begin
            m_rs = RS; m_lsb = LSB; m_rob = ROB;
            m_flushing = 0; e_rs = 0; e_lsb = 0; e_rob = 0; m_stall = 0;
        end else if (!rdy) begin
            e_rs = 0; e_lsb = 0; e_rob = 0;
        end else begin
            if (dv && stall && !m_flushing && m_stall != 64'hFFFF_FFFF) m_stall++;
            if (fl) begin
                m_rs = RS; m_lsb = LSB; m_rob = ROB;
                e_rs = 0; e_lsb = 0; e_rob = 0; m_flushing = 1;
            end else if (m_flushing) begin
                e_rs = 0; e_lsb = 0; e_rob = 0; m_flushing = 0;
            end else begin
                iss   = can;
                e_rob = iss;
                e_rs  = iss && !mem;
                e_lsb = iss && mem;
                m_rs  = cap(m_rs  - int'(e_rs)  + int'(rr), RS);
                m_lsb = cap(m_lsb - int'(e_lsb) + int'(lr), LSB);
                m_rob = cap(m_rob - int'(e_rob) + int'(rc), ROB);
            end
        end
        last_stall = stall;
        last_dv    = dv;
        last_mem   = mem;
        #1;
        chk("issue_rs",   {31'b0, issue_rs},  {31'b0, e_rs});
        chk("issue_lsb",  {31'b0, issue_lsb}, {31'b0, e_lsb});
        chk("issue_rob",  {31'b0, issue_rob}, {31'b0, e_rob});
        chk("rs_credit",  {27'b0, rs_credit},  32'(m_rs));
        chk("lsb_credit", {27'b0, lsb_credit}, 32'(m_lsb));
        chk("rob_credit", {27'b0, rob_credit}, 32'(m_rob));
`ifdef DISPATCH_CTRL_PERF_EN
        chk("stall_cycles", stall_cycles, m_stall[31:0]);
`endif
    endtask

    task automatic refill();
        for (int i = 0; i < 17; i++) step(0, 1, 0, 0, 1, 1, 1, 0);
    endtask

    initial begin
        m_rs = RS; m_lsb = LSB; m_rob = ROB;
        m_flushing = 0; e_rs = 0; e_lsb = 0; e_rob = 0; m_stall = 0;
        last_stall = 0; last_dv = 0; last_mem = 0;
        rst_in = 1; rdy_in = 1; dec_valid = 0; dec_is_mem = 0;
        rs_release = 0; lsb_release = 0; rob_commit = 0; flush = 0;
        @(posedge clk_in); #1;

        // Reset state
        step(1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0, 0, 0);
        chk("reset_rs", {27'b0, rs_credit}, 32'd16);

        // Single ALU dispatch
        step(0, 1, 1, 0, 0, 0, 0, 0);
        chk("t1_rs15", {27'b0, rs_credit}, 32'd15);
        chk("t1_rob15", {27'b0, rob_credit}, 32'd15);
        step(0, 1, 0, 0, 0, 0, 0, 0);

        // Drain RS and ROB, then stall; release at zero does not bypass
        for (int i = 0; i < 15; i++) step(0, 1, 1, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0, 0, 0);
        chk("t2_stall_no_issue", {31'b0, issue_rs}, 32'd0);
        step(0, 1, 1, 0, 1, 0, 1, 0);
        chk("t2_credit1", {27'b0, rs_credit}, 32'd1);
        step(0, 1, 1, 0, 0, 0, 0, 0);
        chk("t2_resume", {31'b0, issue_rs}, 32'd1);
        refill();

        // Mixed stream with structure releases: ROB is the limiter
        for (int i = 0; i < 20; i++)
            step(0, 1, 1, i[0], !i[0], i[0], 0, 0);
        chk("t3_rob0", {27'b0, rob_credit}, 32'd0);
        step(0, 1, 1, 1, 0, 0, 1, 0);
        step(0, 1, 1, 1, 0, 0, 0, 0);
        chk("t3_resume", {31'b0, issue_lsb}, 32'd1);
        refill();

        // Issue with release at 8 holds; release at full saturates
        for (int i = 0; i < 8; i++) step(0, 1, 1, 0, 0, 0, 1, 0);
        step(0, 1, 1, 0, 1, 0, 1, 0);
        chk("t4_hold8", {27'b0, rs_credit}, 32'd8);
        step(0, 1, 0, 0, 0, 1, 0, 0);
        chk("t4_sat16", {27'b0, lsb_credit}, 32'd16);
        refill();

        // Flush from credits 3/5/0
        for (int i = 0; i < 13; i++) step(0, 1, 1, 0, 0, 0, 1, 0);
        for (int i = 0; i < 11; i++) step(0, 1, 1, 1, 0, 0, 1, 0);
        for (int i = 0; i < 16; i++) step(0, 1, 1, 0, 1, 0, 0, 0);
        chk("t5_pre", {rs_credit, lsb_credit, rob_credit}, {17'b0, 5'd3, 5'd5, 5'd0});
        step(0, 1, 1, 0, 0, 0, 0, 1);
        chk("t5_full", {rs_credit, lsb_credit, rob_credit}, {17'b0, 5'd16, 5'd16, 5'd16});
        step(0, 1, 1, 0, 1, 1, 1, 0);
        step(0, 1, 1, 0, 0, 0, 0, 0);
        chk("t5_resume", {31'b0, issue_rob}, 32'd1);

        // rdy_in low freezes everything
        for (int i = 0; i < 4; i++) step(0, 1, 1, i[0], 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 1, 1, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 1, i[0], 0, 0, 0, 0);
        refill();

        // Random traffic; decode holds its instruction while stalled
        for (int i = 0; i < 500; i++) begin
            bit r, rdy, dv, mem, fl;
            r   = ($urandom_range(0, 99) == 0);
            rdy = ($urandom_range(0, 9) != 0);
            fl  = ($urandom_range(0, 29) == 0);
            if (last_stall && last_dv) begin
                dv = 1; mem = last_mem;
            end else begin
                dv  = ($urandom_range(0, 3) != 0);
                mem = $urandom_range(0, 1) == 1;
            end
            step(r, rdy, dv, mem,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 2) == 0, fl);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
